mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: request/response handshake on one side, one-cycle
// read/write strobes on the memory side. Define MEM_ACCESS_CTRL_TIMEOUT_EN to abort stalled reads.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        write,
    output logic        read,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        RSP
    } state_t;

    state_t state;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    logic [7:0] timeout_cnt;
`else
    // Without the timeout build a read can never fail; the expression is 0 for every legal TIMEOUT_CYC.
    assign rsp_err = (TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 255);
`endif

    // The request is captured straight into the memory-side address/data registers at handshake,
    // so the strobe cycle already presents the captured values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            write     <= 1'b0;
            read      <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            rsp_err     <= 1'b0;
            timeout_cnt <= '0;
`endif
        end else begin
            write <= 1'b0;
            read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr      <= req_addr;
                        if (req_write) begin
                            wdata <= req_wdata;
                            write <= 1'b1;
                            state <= WR;
                        end else begin
                            read  <= 1'b1;
                            state <= RD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    rsp_err   <= 1'b0;
`endif
                    state     <= RSP;
                end
                RD: begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    timeout_cnt <= '0;
`endif
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (rvalid) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= RSP;
                    end
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    else if (timeout_cnt == 8'(TIMEOUT_CYC - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RSP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
`endif
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; timeout expectations follow
// whether MEM_ACCESS_CTRL_TIMEOUT_EN is defined for the build.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        write;
    logic        read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .write     (write),
        .read      (read),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({write, read} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {write, read}); end
        n_cmp++; if ({addr, wdata, rsp_rdata} !== 96'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", {addr, wdata, rsp_rdata}); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b want 1", req_ready); end
    endtask

    task automatic test_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        offer(1'b1, a, d);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL %s write_strobe: got %b want 1", tag, write); end
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL %s read_in_wr: got %b want 0", tag, read); end
        n_cmp++; if (addr !== a) begin n_bad++; $display("FAIL %s wr_addr: got %h want %h", tag, addr, a); end
        n_cmp++; if (wdata !== d) begin n_bad++; $display("FAIL %s wr_wdata: got %h want %h", tag, wdata, d); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL %s ready_in_wr: got %b want 0", tag, req_ready); end
        tick();
        n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL %s write_one_cycle: got %b want 0", tag, write); end
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL %s wr_rsp_valid: got %b want 1", tag, rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL %s wr_rsp_err: got %b want 0", tag, rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL %s wr_rsp_rdata: got %h want 0", tag, rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL %s wr_rsp_done: got %b want 0", tag, rsp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL %s wr_back_idle: got %b want 1", tag, req_ready); end
    endtask

    task automatic test_read();
        offer(1'b0, 32'h10, 32'h1234);
        tick();
        req_valid = 1'b0;
        n_cmp++; if ({read, write} !== 2'b10) begin n_bad++; $display("FAIL rd_strobes: got %b want 10", {read, write}); end
        n_cmp++; if (addr !== 32'h10) begin n_bad++; $display("FAIL rd_addr: got %h want 00000010", addr); end
        rvalid = 1'b1;
        rdata  = 32'hA5A5;
        tick();
        n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL rd_one_cycle: got %b want 0", read); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rvalid_in_rd: got %b want 0", rsp_valid); end
        tick();
        rvalid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hA5A5) begin n_bad++; $display("FAIL rd_rsp_rdata: got %h want 0000a5a5", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (wdata !== 32'hA5A5) begin n_bad++; $display("FAIL rd_wdata_hold: got %h want 0000a5a5", wdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_back_idle: got %b want 1", req_ready); end
    endtask

    task automatic test_backpressure();
        offer(1'b0, 32'h20, 32'h0);
        tick();
        req_valid = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h1357;
        tick();
        tick();
        rvalid = 1'b0;
        rdata  = 32'hFFFF;
        offer(1'b1, 32'h30, 32'h42);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_valid[%0d]: got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_rdata !== 32'h1357) begin n_bad++; $display("FAIL bp_rsp_rdata[%0d]: got %h want 00001357", i, rsp_rdata); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, req_ready); end
            n_cmp++; if ({write, read} !== 2'b00) begin n_bad++; $display("FAIL bp_strobes[%0d]: got %b want 00", i, {write, read}); end
            n_cmp++; if (addr !== 32'h20) begin n_bad++; $display("FAIL bp_addr[%0d]: got %h want 00000020", i, addr); end
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_release: got %b want 01", {rsp_valid, req_ready}); end
        tick();
        n_cmp++; if ({write, req_ready} !== 2'b01) begin n_bad++; $display("FAIL bp_not_accepted: got %b want 01", {write, req_ready}); end
    endtask

    task automatic test_timeout();
        offer(1'b0, 32'h40, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        repeat (15) tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL to_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL to_rsp_err: got %b want 1", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL to_rsp_rdata: got %h want 0", rsp_rdata); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL to_back_idle: got %b want 1", req_ready); end
`else
        repeat (20) tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL nto_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if ({req_ready, read, rsp_err} !== 3'b000) begin n_bad++; $display("FAIL nto_waiting: got %b want 000", {req_ready, read, rsp_err}); end
        reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL nto_recover: got %b want 1", req_ready); end
`endif
    endtask

    task automatic test_reset_mid_read();
        offer(1'b0, 32'h50, 32'h0);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (read !== 1'b1) begin n_bad++; $display("FAIL mr_read_strobe: got %b want 1", read); end
        tick();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if ({read, write, rsp_valid, req_ready} !== 4'b0000) begin n_bad++; $display("FAIL mr_async_clear: got %b want 0000", {read, write, rsp_valid, req_ready}); end
        n_cmp++; if (addr !== 32'd0) begin n_bad++; $display("FAIL mr_addr_clear: got %h want 0", addr); end
        @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD;
        tick();
        n_cmp++; if ({req_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL mr_post_reset: got %b want 10", {req_ready, rsp_valid}); end
        tick();
        rvalid = 1'b0;
        n_cmp++; if ({req_ready, rsp_valid, read} !== 3'b100) begin n_bad++; $display("FAIL mr_late_rvalid: got %b want 100", {req_ready, rsp_valid, read}); end
        test_write(32'h60, 32'h99, "post_reset");
    endtask

    task automatic test_stray_rvalid();
        rvalid = 1'b1;
        rdata  = 32'h33;
        repeat (2) begin
            tick();
            n_cmp++; if ({rsp_valid, req_ready} !== 2'b01) begin n_bad++; $display("FAIL stray_idle: got %b want 01", {rsp_valid, req_ready}); end
        end
        rvalid = 1'b0;
        offer(1'b0, 32'h70, 32'h0);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (addr !== 32'h70) begin n_bad++; $display("FAIL stray_rd_addr: got %h want 00000070", addr); end
        repeat (4) tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stray_wait: got %b want 0", rsp_valid); end
        rvalid = 1'b1;
        rdata  = 32'h77;
        tick();
        rvalid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL stray_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h77) begin n_bad++; $display("FAIL stray_rsp_rdata: got %h want 00000077", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL stray_rsp_err: got %b want 0", rsp_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write(32'h10, 32'hA5A5, "basic");
        test_read();
        test_backpressure();
        test_timeout();
        test_reset_mid_read();
        test_stray_rvalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
